// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with a valid/ready
// handshake and a 2-entry skid buffer (main + skid). Every output is taken
// directly from a flop, so downstream ready never reaches upstream ready
// combinationally. Supports flush with NOP insertion and saturating
// stall/flush performance counters.
module pipe_stage_skid #(
  parameter int               WIDTH     = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,      // synchronous, active-low
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Occupancy of the stage: EMPTY, ONE (main only), TWO (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;    // oldest payload, drives out_data
  logic [WIDTH-1:0]   skid_q, skid_d;    // younger payload
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic push;
  logic pop;

  // Handshakes use the registered ready/valid, never the live opposite side.
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next-state and next-data for the two-entry buffer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Any push/pop completing at the ports this cycle is dropped.
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end

    // Handshake flags are decoded from the next state so they come out of
    // flops in the cycle the new state takes effect.
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && !flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, payload and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      // NOTE: the payload entries are reset too, because main_q drives
      // out_data directly and must read NOP_VALUE while nothing is held.
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios followed by random
// traffic, checked against a queue-based reference model (a FIFO of at most
// two payloads) and a scoreboard that compares every popped payload.
module tb_pipe_stage_skid;

  localparam int               WIDTH   = 32;
  localparam logic [WIDTH-1:0] NOP     = 32'h0BAD_F00D;
  localparam int               CNT_W   = 4;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: payloads in arrival order plus the two counters.
  logic [WIDTH-1:0] exp_q[$];
  int               m_stall = 0;
  int               m_flush = 0;
  bit               mon_en  = 1'b0;

  pipe_stage_skid #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update and scoreboard: evaluated on the same edge the DUT uses.
  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    if (!reset) begin
      exp_q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      do_pop  = (exp_q.size() > 0) && out_ready;
      do_push = in_valid && (exp_q.size() < 2);
      if (flush) begin
        exp_q.delete();
        if (m_flush < CNT_MAX) m_flush++;
      end else begin
        if (exp_q.size() > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
        if (do_pop) begin
          check("sb_pop_data", out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (do_push) exp_q.push_back(in_data);
      end
    end
  end

  // Monitor: compares every output against the model away from the edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_out_valid", out_valid, exp_q.size() > 0);
      check("mon_out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : NOP);
      check("mon_in_ready", in_ready, exp_q.size() < 2);
      check("mon_stall_cnt", stall_cnt, m_stall);
      check("mon_flush_cnt", flush_cnt, m_flush);
    end
  end

  // One clock; inputs change 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset then idle.
    cyc(); cyc();
    mon_en = 1'b1;
    reset  = 1'b1;
    cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, NOP);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);

    // Streaming with out_ready held high: one-cycle latency, no bubbles.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = WIDTH'(i);
      cyc();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, i);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    cyc();
    check("stream_drained", out_valid, 0);

    // Back-pressure fills the skid entry.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    cyc();
    in_data   = 32'hB;
    cyc();
    in_valid  = 1'b0;
    cyc();
    check("bp_in_ready", in_ready, 0);
    check("bp_out_data", out_data, 32'hA);
    check("bp_stall_cnt", stall_cnt, 2);
    out_ready = 1'b1;
    cyc();
    check("bp_pop_b", out_data, 32'hB);
    check("bp_ready_back", in_ready, 1);
    cyc();
    check("bp_empty", out_valid, 0);

    // Flush while TWO with a simultaneous pop attempt.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC1;
    cyc();
    in_data   = 32'hC2;
    cyc();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hC3;
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_out_data", out_data, NOP);
    check("fl_in_ready", in_ready, 1);
    check("fl_flush_cnt", flush_cnt, 1);
    cyc();
    check("fl_no_reappear", out_valid, 0);

    // Reset mid-operation while TWO with stall_cnt = 5.
    reset = 1'b0;
    cyc();
    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD1;
    cyc();
    in_data   = 32'hD2;
    cyc();
    in_valid  = 1'b0;
    repeat (4) cyc();
    check("mid_stall5", stall_cnt, 5);
    check("mid_two", in_ready, 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_stall_clr", stall_cnt, 0);

    // Stall counter saturation.
    in_valid = 1'b1;
    in_data  = 32'hE1;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("sat_stall", stall_cnt, CNT_MAX);
    cyc();
    check("sat_hold", stall_cnt, CNT_MAX);
    out_ready = 1'b1;
    cyc();

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 99) != 0);
      cyc();
    end
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    cyc();
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed IF/ID pipeline register.
- Generic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer, so upstream is never back-pressured combinationally.
- Supports flush with NOP insertion and has saturating stall/flush performance counters.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, …) with the stage payload packed into one bus.

Parameters:
- WIDTH, 96, payload width in bits (default packs pc_inc, pc_original, instr).
- NOP_VALUE, 96'h0, value driven on out_data whenever out_valid=0; also written into entries on flush.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- flush  input  1  discard all held entries this cycle.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; registered, equals "skid entry empty".
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  payload valid to downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  oldest held payload, or NOP_VALUE when out_valid=0.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- flush_cnt  output  CNT_W  cycles with flush=1, saturating.

Behaviour:
- Reset (reset=0 at posedge):
  - state=EMPTY; main and skid entries = NOP_VALUE.
  - out_valid=0, out_data=NOP_VALUE, in_ready=1.
  - stall_cnt=0, flush_cnt=0.
  - Reset overrides flush and all handshakes, including mid-operation in any state.
- Transfer definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main entry drives out_data; skid entry holds the younger payload. out_valid=1 in states ONE and TWO; in_ready=1 in states EMPTY and ONE.
- State machine (evaluated when reset=1 and flush=0):
  - EMPTY: push → ONE, main<=in_data.
  - ONE: push & pop → ONE, main<=in_data. Push only → TWO, skid<=in_data. Pop only → EMPTY, main<=NOP_VALUE. Neither → hold.
  - TWO: in_ready=0, so no push. Pop → ONE, main<=skid, skid<=NOP_VALUE. No pop → hold.
- Latency: one cycle from push to out_valid when the stage is EMPTY; zero-bubble throughput when out_ready is held high.
- Ordering: strictly FIFO; the main entry is always older than the skid entry.
- Flush (reset=1, flush=1):
  - Next state EMPTY; main and skid <= NOP_VALUE; out_valid=0 next cycle.
  - A push or pop in the same cycle is discarded (the handshake may still complete at the ports; payload is dropped).
  - in_ready=1 on the following cycle.
- Counters:
  - stall_cnt increments on a cycle with out_valid=1 & out_ready=0 & flush=0.
  - flush_cnt increments on a cycle with flush=1.
  - Both saturate at all-ones (no wrap) and are cleared only by reset.
- No combinational path from out_ready to in_ready. in_ready, out_valid and out_data are register outputs.

Test Plan:
- Reset then idle: assert reset=0 for 2 cycles, release → out_valid=0, out_data=0, in_ready=1, both counters=0.
- Streaming: out_ready=1; push 0x1, 0x2, 0x3 on consecutive cycles → out_data=0x1, 0x2, 0x3 on the next three cycles with out_valid=1; in_ready stays 1.
- Back-pressure/skid: out_ready=0; push 0xA, then 0xB → state TWO, in_ready=0, out_data=0xA, stall_cnt increments each stalled cycle (=2 after two stalled cycles). Raise out_ready → 0xA then 0xB popped in order, in_ready returns to 1.
- Flush in TWO with a simultaneous pop attempt: flush=1 → next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1, flush_cnt=1. Neither held payload reappears.
- Counter saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays at 15.
- Reset mid-operation: in state TWO with stall_cnt=5, drive reset=0 → next cycle EMPTY, out_valid=0, in_ready=1, stall_cnt=0.
